// File: rtl/call_return_unit_if.sv
// Sequencer and LIFO signal bundle for call_return_unit.
// slave: the unit; master: sequencer plus LIFO side.
interface call_return_unit_if;
  logic        call_req;
  logic        ret_req;
  logic [15:0] ret_addr_in;
  logic        fault_clear;
  logic        lifo_full;
  logic        lifo_empty;
  logic [15:0] lifo_q;
  logic        lifo_push;
  logic        lifo_pop;
  logic [15:0] lifo_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] pc_target;
  logic        overflow;
  logic        underflow;
  logic        sync_err;

  modport slave (
    input  call_req, ret_req, ret_addr_in, fault_clear,
    input  lifo_full, lifo_empty, lifo_q,
    output lifo_push, lifo_pop, lifo_data,
    output busy, done, err, pc_target,
    output overflow, underflow, sync_err
  );

  modport master (
    output call_req, ret_req, ret_addr_in, fault_clear,
    output lifo_full, lifo_empty, lifo_q,
    input  lifo_push, lifo_pop, lifo_data,
    input  busy, done, err, pc_target,
    input  overflow, underflow, sync_err
  );
endinterface

// File: rtl/call_return_unit.sv
// CALL/RET initiator for a 16-bit hardware LIFO return-address stack.
// Ports: clock, reset (sync, active-high), bus (call_return_unit_if.slave):
//   requests/fault_clear in, LIFO flags/data in, strobes/done/err/pc/faults out.
// Optional: CALLRET_SHADOW_CHECK_EN adds a shadow depth counter driving sync_err.
module call_return_unit #(
  parameter int DEPTH        = 16,
  parameter int LOG2_DEPTHP1 = 5
) (
  input  logic               clock,
  input  logic               reset,
  call_return_unit_if.slave  bus
);

  // Parameter sanity: the counter must hold 0..DEPTH.
  if (LOG2_DEPTHP1 != $clog2(DEPTH + 1)) begin : g_bad_cfg
    $error("LOG2_DEPTHP1 must be clog2(DEPTH+1)");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        op_ret_q, op_ret_d;
  logic        push_q, push_d;
  logic        pop_q, pop_d;
  logic        err_q, err_d;
  logic [15:0] data_q, data_d;
  logic [15:0] pc_q, pc_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  always_comb begin
    state_d  = state_q;
    op_ret_d = op_ret_q;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    err_d    = 1'b0;
    data_d   = data_q;
    pc_d     = pc_q;
    // A new fault below overrides a same-cycle clear.
    ovf_d    = bus.fault_clear ? 1'b0 : ovf_q;
    udf_d    = bus.fault_clear ? 1'b0 : udf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.call_req && bus.ret_req) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (bus.call_req) begin
          op_ret_d = 1'b0;
          if (bus.lifo_full) begin
            ovf_d   = 1'b1;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            data_d  = bus.ret_addr_in;
            push_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end else if (bus.ret_req) begin
          op_ret_d = 1'b1;
          if (bus.lifo_empty) begin
            udf_d   = 1'b1;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            pop_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // LIFO read data is valid one cycle after the pop edge.
        if (op_ret_q) begin
          pc_d = bus.lifo_q;
        end
        state_d = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_ret_q <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= 16'h0000;
      pc_q     <= 16'h0000;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_ret_q <= op_ret_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      err_q    <= err_d;
      data_q   <= data_d;
      pc_q     <= pc_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef CALLRET_SHADOW_CHECK_EN
  logic [LOG2_DEPTHP1-1:0] cnt_q, cnt_d;
  logic                    serr_q, serr_d;
  logic                    cnt_full, cnt_empty;

  // Counter moves at accept so CAPTURE sees the post-op depth,
  // matching the LIFO's registered flags.
  assign cnt_full  = (cnt_q == LOG2_DEPTHP1'(DEPTH));
  assign cnt_empty = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    serr_d = bus.fault_clear ? 1'b0 : serr_q;
    if (push_d) begin
      cnt_d = cnt_q + LOG2_DEPTHP1'(1);
    end else if (pop_d) begin
      cnt_d = cnt_q - LOG2_DEPTHP1'(1);
    end
    if (state_q == S_CAPTURE &&
        ((cnt_full != bus.lifo_full) ||
         (cnt_empty != bus.lifo_empty))) begin
      serr_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      serr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      serr_q <= serr_d;
    end
  end

  assign bus.sync_err = serr_q;
`else
  assign bus.sync_err = 1'b0;
`endif

  assign bus.lifo_push = push_q;
  assign bus.lifo_pop  = pop_q;
  assign bus.lifo_data = data_q;
  assign bus.busy      = (state_q == S_ISSUE) || (state_q == S_CAPTURE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign bus.pc_target = pc_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

endmodule
